// File: rtl/imc_instr_sequencer_if.sv
// Host-side valid/ready instruction port for the IMC sequencer.
interface imc_instr_sequencer_if #(
  parameter int INSTRUCTION_SIZE = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic [INSTRUCTION_SIZE-1:0] in_instruction;

  modport master (
    output in_valid,
    output in_instruction,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_instruction,
    output in_ready
  );
endinterface

// File: rtl/imc_instr_sequencer.sv
// Buffers host RRAM instructions and issues them to the decoder one at a
// time, holding each for an opcode-dependent time plus one idle gap cycle.
module imc_instr_sequencer #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int WRITE_CYCLES = 4,
  parameter int READ_CYCLES = 2,
  parameter logic [INSTRUCTION_SIZE-1:0] IDLE_INSTR = 32'hF000_0000
) (
  input  logic clk,
  input  logic rst,
  imc_instr_sequencer_if.slave host,
  input  logic flush,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic issue_start,
  output logic busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int MAXL =
    (WRITE_CYCLES > READ_CYCLES) ? WRITE_CYCLES : READ_CYCLES;
  localparam int HW = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0] state;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [INSTRUCTION_SIZE-1:0] mem [FIFO_DEPTH];
  logic [INSTRUCTION_SIZE-1:0] head;
  logic push;
  logic pop;

  function automatic logic [HW-1:0] hold_m1(input logic [3:0] op);
    logic [HW-1:0] h;
    h = '0;
    unique case (1'b1)
      (op == 4'b1000):     h = HW'(WRITE_CYCLES - 1);
      (op[3:1] == 3'b000): h = HW'(READ_CYCLES - 1);
      default:             h = '0;
    endcase
    return h;
  endfunction

  assign host.in_ready = (fifo_count < DEPTH_C) & ~flush;
  assign push = host.in_valid & host.in_ready;
  // Pop decision uses the registered count, so a same-cycle push is unseen.
  assign pop = (state != S_ISSUE) && (fifo_count != '0);
  assign head = mem[rd_ptr];
  assign busy = (state != S_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= host.in_instruction;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      instruction <= IDLE_INSTR;
      issue_start <= 1'b0;
      hold_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      instruction <= IDLE_INSTR;
      issue_start <= 1'b0;
      hold_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      issue_start <= 1'b0;
      if (pop) begin
        instruction <= head;
        hold_cnt <= hold_m1(head[INSTRUCTION_SIZE-1 -: 4]);
        issue_start <= 1'b1;
        state <= S_ISSUE;
      end else begin
        case (state)
          S_ISSUE: begin
            if (hold_cnt == '0) begin
              instruction <= IDLE_INSTR;
              state <= S_GAP;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          S_GAP:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/imc_instr_sequencer.md
# imc_instr_sequencer

Instruction sequencer that sits directly upstream of `instruction_decoder_RRAM`. It accepts 32-bit RRAM array instructions from the host through a valid/ready port and buffers them in a small FIFO. It then presents them one at a time on the decoder's `instruction` input, holding each for an opcode-dependent number of cycles and separating consecutive instructions with one idle cycle. The decoder therefore never sees two array operations back-to-back.

## Interface
- `INSTRUCTION_SIZE`, 32: instruction width.
- `FIFO_DEPTH`, 4: buffer entries; must be a power of two, ≥ 2.
- `WRITE_CYCLES`, 4: hold time of a WRITE instruction, in cycles; ≥ 1.
- `READ_CYCLES`, 2: hold time of a READ instruction, in cycles; ≥ 1.
- `IDLE_INSTR`, 32'hF000_0000: value driven to the decoder when nothing is issued (opcode 4'hF = idle).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  host instruction valid.
- `in_ready`  out  1  FIFO can accept; combinational from registered count and `flush`.
- `in_instruction`  in  INSTRUCTION_SIZE  host instruction.
- `flush`  in  1  synchronous; drops the FIFO and aborts the current issue.
- `instruction`  out  INSTRUCTION_SIZE  registered; goes to the decoder's `instruction` input.
- `issue_start`  out  1  registered; high for the first cycle a new instruction is on `instruction`.
- `busy`  out  1  high when the state is not IDLE or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

## Operation
- Instruction fields:
  - opcode = [31:28]; row = [7:4]; col = [3:0].
  - Opcode 4'b1000 is WRITE and holds for WRITE_CYCLES.
  - Opcodes 4'b0000 and 4'b0001 are READ and hold for READ_CYCLES.
  - Any other opcode holds for 1 cycle.
  - The sequencer passes the word through unmodified.
- Push: `in_valid & in_ready` at a rising edge writes to the tail.
  - `in_ready = (fifo_count < FIFO_DEPTH) & ~flush`.
  - A same-cycle pop does not make room: a full FIFO deasserts `in_ready` even if it pops that cycle.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: `instruction = IDLE_INSTR`. If `fifo_count != 0`, pop the head, load it into `instruction`, load `hold_cnt = L-1` (L is the opcode hold time), assert `issue_start` and go to ISSUE.
  - ISSUE: hold `instruction`. If `hold_cnt == 0`, load `IDLE_INSTR` and go to GAP; otherwise decrement `hold_cnt`.
  - GAP: lasts exactly one cycle with `instruction = IDLE_INSTR`. If the FIFO is non-empty, pop and enter ISSUE as IDLE does; otherwise go to IDLE.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged. A push into an empty FIFO is not visible to the pop decision in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. The count saturates at neither end, because the handshake makes overflow and underflow impossible.
- `flush` has priority over everything except `rst`. At the edge it:
  - clears the pointers and count;
  - drops any concurrent push;
  - sets the state to IDLE, `instruction = IDLE_INSTR`, `issue_start = 0`.

## Timing
- Reset values:
  - state IDLE;
  - `instruction = IDLE_INSTR`;
  - `issue_start = 0`;
  - `fifo_count = 0`;
  - `busy = 0`;
  - `in_ready = 1`, unless `flush` is high.
- Latency into an idle, empty sequencer: an instruction accepted at edge N appears on `instruction` after edge N+1.
- An instruction of hold L occupies `instruction` for exactly L cycles, followed by one IDLE_INSTR cycle.
- Back-to-back issue period is L+1 cycles; a stream of WRITEs issues every 5 cycles with default parameters.
- Asserting `rst` mid-issue forces the reset values immediately (asynchronous), with no partial instruction retained. The first push is accepted at the first rising edge after `rst` deasserts.
- `issue_start` is high only during the first of the L hold cycles.

## Test plan
- **Reset:** with `rst` high, drive `in_valid` with traffic.
  - Required: `instruction = 32'hF000_0000`, `fifo_count = 0`, no push accepted.
  - Release `rst`. Required: `in_ready = 1`.
- **Single WRITE:** push 32'h8000_0015 (row 1, col 5) at edge N.
  - Required: `instruction = 32'h8000_0015` from after edge N+1 for 4 cycles, with `issue_start` high in the first.
  - Then IDLE_INSTR, then IDLE with `busy = 0`.
- **Mixed burst:** push 32'h1000_0027, 32'h1000_002A, 32'h8000_007E in consecutive cycles.
  - Required: each READ held 2 cycles, the WRITE held 4, and one IDLE_INSTR cycle between each.
  - Required: `fifo_count` peaks at 2 or 3 with no loss or reordering.
- **Full FIFO:** stall the drain by pushing WRITEs continuously.
  - Required: `in_ready` drops when `fifo_count = 4`.
  - Required: `in_ready` rises only after a pop edge, and no entries are dropped.
- **Flush mid-WRITE:** assert `flush` in the 2nd hold cycle with 2 entries queued and `in_valid` high.
  - Required: next cycle `instruction = IDLE_INSTR` and `fifo_count = 0`.
  - Required: the same-cycle push is dropped.
- **Async reset mid-READ:** pulse `rst` for half a cycle.
  - Required: `instruction = IDLE_INSTR` immediately, without waiting for a clock edge.
  - Required: a subsequent push of 32'h1000_00BA issues normally.
